// File: rtl/digital_lock_fsm_param.sv
// Parametrised combination-lock controller: code set/verify, armed unlock,
// failure counting with permanent or timed lockout.
module digital_lock_fsm_param #(
  parameter int unsigned KEY_W         = 4,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned MAX_TRIES     = 4,
  parameter int unsigned FREEZE_CYCLES = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [KEY_W-1:0]                 key,
  input  logic                             key_valid,
  input  logic                             cancel,
  output logic                             locked,
  output logic                             error,
  output logic                             frozen,
  output logic                             unlock_pulse,
  output logic [$clog2(DIGITS+1)-1:0]      digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int unsigned CODE_W = DIGITS * KEY_W;
  localparam int unsigned DCNT_W = $clog2(DIGITS + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W  = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;

  localparam logic [TMR_W-1:0]  TMR_LOAD = (FREEZE_CYCLES == 0) ? '0 : TMR_W'(FREEZE_CYCLES - 1);
  localparam logic [TRY_W-1:0]  MAX_T    = TRY_W'(MAX_TRIES);
  localparam logic [DCNT_W-1:0] LAST_D   = DCNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_SET    = 2'd0,
    ST_VERIFY = 2'd1,
    ST_ARMED  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  state_e              state_q,  state_d;
  logic [CODE_W-1:0]   pwd_q,    pwd_d;
  logic [CODE_W-1:0]   buf_q,    buf_d;
  logic [DCNT_W-1:0]   cnt_q,    cnt_d;
  logic [TRY_W-1:0]    fail_q,   fail_d;
  logic [TMR_W-1:0]    tmr_q,    tmr_d;
  logic                error_q,  error_d;
  logic                unlock_q, unlock_d;
  logic                locked_q, locked_d;
  logic                frozen_q, frozen_d;
  logic [TRY_W-1:0]    tries_q,  tries_d;

  logic [CODE_W-1:0]   code_c;
  logic                match_c;
  logic [TRY_W-1:0]    fail_inc_c;

  // Entry as it would stand with the current key included (zero-latency compare).
  always_comb begin
    code_c = buf_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt_q == DCNT_W'(i)) code_c[i*KEY_W +: KEY_W] = key;
    end
    match_c    = (code_c == pwd_q);
    fail_inc_c = fail_q + TRY_W'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    pwd_d    = pwd_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    error_d  = error_q;
    unlock_d = 1'b0;

    if (state_q == ST_FREEZE) begin
      if (FREEZE_CYCLES != 0) begin
        if (tmr_q == '0) begin
          state_d = ST_ARMED;
          fail_d  = '0;
          error_d = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
    end else if (cancel) begin
      buf_d = '0;
      cnt_d = '0;
      if (state_q == ST_VERIFY) begin
        pwd_d   = '0;
        state_d = ST_SET;
      end
    end else if (key_valid) begin
      if (cnt_q != LAST_D) begin
        buf_d = code_c;
        cnt_d = cnt_q + DCNT_W'(1);
      end else begin
        buf_d = '0;
        cnt_d = '0;
        unique case (state_q)
          ST_SET: begin
            pwd_d   = code_c;
            state_d = ST_VERIFY;
          end
          ST_VERIFY: begin
            error_d = ~match_c;
            if (match_c) state_d = ST_ARMED;
          end
          ST_ARMED: begin
            if (match_c) begin
              state_d  = ST_SET;
              pwd_d    = '0;
              unlock_d = 1'b1;
              error_d  = 1'b0;
              fail_d   = '0;
            end else begin
              error_d = 1'b1;
              fail_d  = fail_inc_c;
              if (fail_inc_c >= MAX_T) begin
                state_d = ST_FREEZE;
                tmr_d   = TMR_LOAD;
              end
            end
          end
          default: ;
        endcase
      end
    end

    locked_d = (state_d == ST_ARMED) || (state_d == ST_FREEZE);
    frozen_d = (state_d == ST_FREEZE);
    tries_d  = frozen_d ? '0 : (MAX_T - fail_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SET;
      pwd_q    <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      tmr_q    <= '0;
      error_q  <= 1'b0;
      unlock_q <= 1'b0;
      locked_q <= 1'b0;
      frozen_q <= 1'b0;
      tries_q  <= MAX_T;
    end else begin
      state_q  <= state_d;
      pwd_q    <= pwd_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      error_q  <= error_d;
      unlock_q <= unlock_d;
      locked_q <= locked_d;
      frozen_q <= frozen_d;
      tries_q  <= tries_d;
    end
  end

  assign locked       = locked_q;
  assign error        = error_q;
  assign frozen       = frozen_q;
  assign unlock_pulse = unlock_q;
  assign digit_count  = cnt_q;
  assign tries_left   = tries_q;

endmodule

// File: tb/tb_digital_lock_fsm_param.sv
// Bench for digital_lock_fsm_param: a permanent-lockout and a timed-lockout
// instance driven in lockstep, checked against a key-list reference model.
module tb_digital_lock_fsm_param;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key = '0;
  logic       key_valid = 1'b0;
  logic       cancel = 1'b0;

  logic       locked, error, frozen, unlock_pulse;
  logic [2:0] digit_count, tries_left;
  logic       locked_t, error_t, frozen_t, unlock_pulse_t;
  logic [2:0] digit_count_t;
  logic [1:0] tries_left_t;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  digital_lock_fsm_param dut (
    .clock(clock), .reset_n(reset_n), .key(key), .key_valid(key_valid), .cancel(cancel),
    .locked(locked), .error(error), .frozen(frozen), .unlock_pulse(unlock_pulse),
    .digit_count(digit_count), .tries_left(tries_left)
  );

  digital_lock_fsm_param #(.MAX_TRIES(2), .FREEZE_CYCLES(8)) dut_t (
    .clock(clock), .reset_n(reset_n), .key(key), .key_valid(key_valid), .cancel(cancel),
    .locked(locked_t), .error(error_t), .frozen(frozen_t), .unlock_pulse(unlock_pulse_t),
    .digit_count(digit_count_t), .tries_left(tries_left_t)
  );

  // Reference model: index 0 = default instance, 1 = timed instance.
  localparam int M_SET = 0, M_VER = 1, M_ARM = 2, M_FRZ = 3;
  int m_st[2], m_pwd[2][4], m_ent[2][4], m_n[2], m_fail[2], m_tmr[2], m_err[2], m_up[2];

  function automatic int max_of(input int id);
    return (id == 0) ? 4 : 2;
  endfunction

  function automatic int fc_of(input int id);
    return (id == 0) ? 0 : 8;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_st[id] = M_SET; m_n[id] = 0; m_fail[id] = 0; m_tmr[id] = 0;
      m_err[id] = 0; m_up[id] = 0;
      for (int j = 0; j < 4; j++) begin m_pwd[id][j] = 0; m_ent[id][j] = 0; end
    end
  endtask

  task automatic model_step(input int id, input bit kv, input bit cn, input int k);
    bit same;
    m_up[id] = 0;
    if (m_st[id] == M_FRZ) begin
      if (fc_of(id) != 0) begin
        if (m_tmr[id] == 0) begin
          m_st[id] = M_ARM; m_fail[id] = 0; m_err[id] = 0;
        end else m_tmr[id]--;
      end
      return;
    end
    if (cn) begin
      m_n[id] = 0;
      if (m_st[id] == M_VER) begin
        m_st[id] = M_SET;
        for (int j = 0; j < 4; j++) m_pwd[id][j] = 0;
      end
      return;
    end
    if (!kv) return;
    m_ent[id][m_n[id]] = k;
    m_n[id]++;
    if (m_n[id] < 4) return;
    m_n[id] = 0;
    same = 1;
    for (int j = 0; j < 4; j++) if (m_ent[id][j] != m_pwd[id][j]) same = 0;
    case (m_st[id])
      M_SET: begin
        for (int j = 0; j < 4; j++) m_pwd[id][j] = m_ent[id][j];
        m_st[id] = M_VER;
      end
      M_VER: begin
        m_err[id] = same ? 0 : 1;
        if (same) m_st[id] = M_ARM;
      end
      default: begin
        if (same) begin
          m_st[id] = M_SET; m_up[id] = 1; m_err[id] = 0; m_fail[id] = 0;
          for (int j = 0; j < 4; j++) m_pwd[id][j] = 0;
        end else begin
          m_err[id] = 1;
          m_fail[id]++;
          if (m_fail[id] >= max_of(id)) begin
            m_st[id] = M_FRZ;
            m_tmr[id] = fc_of(id) - 1;
          end
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("d.locked", 32'(locked), (m_st[0] == M_ARM || m_st[0] == M_FRZ) ? 1 : 0);
    chk("d.error", 32'(error), m_err[0]);
    chk("d.frozen", 32'(frozen), (m_st[0] == M_FRZ) ? 1 : 0);
    chk("d.unlock", 32'(unlock_pulse), m_up[0]);
    chk("d.digit_count", 32'(digit_count), m_n[0]);
    chk("d.tries_left", 32'(tries_left), (m_st[0] == M_FRZ) ? 0 : max_of(0) - m_fail[0]);
    chk("t.locked", 32'(locked_t), (m_st[1] == M_ARM || m_st[1] == M_FRZ) ? 1 : 0);
    chk("t.error", 32'(error_t), m_err[1]);
    chk("t.frozen", 32'(frozen_t), (m_st[1] == M_FRZ) ? 1 : 0);
    chk("t.unlock", 32'(unlock_pulse_t), m_up[1]);
    chk("t.digit_count", 32'(digit_count_t), m_n[1]);
    chk("t.tries_left", 32'(tries_left_t), (m_st[1] == M_FRZ) ? 0 : max_of(1) - m_fail[1]);
  endtask

  task automatic step(input bit kv, input bit cn, input logic [3:0] k);
    @(negedge clock);
    key = k; key_valid = kv; cancel = cn;
    @(posedge clock);
    model_step(0, kv, cn, int'(k));
    model_step(1, kv, cn, int'(k));
    #1;
    check_models();
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    step(1, 0, a); step(1, 0, b); step(1, 0, c); step(1, 0, d);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clock);
    #2 reset_n = 1'b0;
    key_valid = 1'b0; cancel = 1'b0; key = '0;
    #1;
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".error"}, 32'(error), 0);
    chk({tag, ".frozen"}, 32'(frozen), 0);
    chk({tag, ".unlock"}, 32'(unlock_pulse), 0);
    chk({tag, ".digit_count"}, 32'(digit_count), 0);
    chk({tag, ".tries_left"}, 32'(tries_left), 4);
    chk({tag, ".t.frozen"}, 32'(frozen_t), 0);
    chk({tag, ".t.tries_left"}, 32'(tries_left_t), 2);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit kv; bit cn; logic [3:0] k;
    bit lk; bit er; bit fz; bit up; int dc; int tl;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit kv, input bit cn, input logic [3:0] k, input bit lk, input bit er,
                     input bit fz, input bit up, input int dc, input int tl);
    vec_t v;
    v.kv = kv; v.cn = cn; v.k = k; v.lk = lk; v.er = er; v.fz = fz; v.up = up; v.dc = dc; v.tl = tl;
    vecs.push_back(v);
  endtask

  // Four key rows: first three share the "mid" outputs, the last carries the completion outputs.
  task automatic add_entry(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                           input bit lk_m, input bit er_m, input int tl_m,
                           input bit lk_e, input bit er_e, input bit fz_e, input bit up_e, input int tl_e);
    add(1, 0, a, lk_m, er_m, 0, 0, 1, tl_m);
    add(1, 0, b, lk_m, er_m, 0, 0, 2, tl_m);
    add(1, 0, c, lk_m, er_m, 0, 0, 3, tl_m);
    add(1, 0, d, lk_e, er_e, fz_e, up_e, 0, tl_e);
  endtask

  initial begin : main
    int cyc;
    bit kv, cn;
    logic [3:0] k;

    add_entry(1, 0, 2, 3, 0, 0, 4, 0, 0, 0, 0, 4);
    add_entry(1, 0, 2, 3, 0, 0, 4, 1, 0, 0, 0, 4);
    add_entry(1, 0, 2, 4, 1, 0, 4, 1, 1, 0, 0, 3);
    add_entry(1, 0, 2, 3, 1, 1, 3, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 4);
    add_entry(1, 0, 2, 3, 0, 0, 4, 0, 0, 0, 0, 4);
    add_entry(1, 0, 2, 3, 0, 0, 4, 1, 0, 0, 0, 4);
    add(1, 0, 1, 1, 0, 0, 0, 1, 4);
    add(1, 0, 0, 1, 0, 0, 0, 2, 4);
    add(1, 1, 2, 1, 0, 0, 0, 0, 4);
    add_entry(1, 0, 2, 3, 1, 0, 4, 0, 0, 0, 1, 4);
    add_entry(5, 5, 5, 5, 0, 0, 4, 0, 0, 0, 0, 4);
    add_entry(5, 5, 5, 6, 0, 0, 4, 0, 1, 0, 0, 4);
    add_entry(5, 5, 5, 5, 0, 1, 4, 1, 0, 0, 0, 4);
    add_entry(0, 0, 0, 0, 1, 0, 4, 1, 1, 0, 0, 3);
    add_entry(0, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 2);
    add_entry(0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, 1);
    add_entry(0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0);

    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_models();

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].kv, vecs[i].cn, vecs[i].k);
      chk($sformatf("vec%0d.locked", i), 32'(locked), 32'(vecs[i].lk));
      chk($sformatf("vec%0d.error", i), 32'(error), 32'(vecs[i].er));
      chk($sformatf("vec%0d.frozen", i), 32'(frozen), 32'(vecs[i].fz));
      chk($sformatf("vec%0d.unlock", i), 32'(unlock_pulse), 32'(vecs[i].up));
      chk($sformatf("vec%0d.digit_count", i), 32'(digit_count), 32'(vecs[i].dc));
      chk($sformatf("vec%0d.tries_left", i), 32'(tries_left), 32'(vecs[i].tl));
    end

    // Permanent freeze ignores keys and cancels.
    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    chk("perm.frozen", 32'(frozen), 1);
    chk("perm.error", 32'(error), 1);
    chk("perm.locked", 32'(locked), 1);
    do_reset("perm_rst");

    // Timed freeze lasts exactly eight cycles, then the stored code still unlocks.
    enter(1, 0, 2, 3);
    enter(1, 0, 2, 3);
    enter(0, 0, 0, 0);
    chk("timed.tries_after1", 32'(tries_left_t), 1);
    enter(0, 0, 0, 0);
    chk("timed.frozen_on", 32'(frozen_t), 1);
    cyc = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      if (frozen_t) cyc++;
      else break;
    end
    chk("timed.freeze_len", 32'(cyc), 8);
    chk("timed.tries_back", 32'(tries_left_t), 2);
    chk("timed.error_clr", 32'(error_t), 0);
    chk("timed.locked", 32'(locked_t), 1);
    enter(1, 0, 2, 3);
    chk("timed.unlock", 32'(unlock_pulse_t), 1);
    step(0, 0, 0);
    chk("timed.unlock_1cyc", 32'(unlock_pulse_t), 0);

    // Reset mid-entry.
    step(1, 0, 7);
    step(1, 0, 8);
    chk("mid.digit_count", 32'(digit_count), 2);
    do_reset("mid_rst");

    // Randomised traffic with keys biased to a small alphabet so codes match often.
    for (int r = 0; r < 6; r++) begin
      enter(1, 0, 1, 1);
      enter(1, 0, 1, 1);
      for (int i = 0; i < 450; i++) begin
        kv = 1'($urandom_range(0, 1));
        cn = ($urandom_range(0, 19) == 0);
        k  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
        step(kv, cn, k);
      end
      do_reset($sformatf("rnd_rst%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
